// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage load/store unit with data-memory handshake, lane steering and fault detection
module mem_access_stage #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_mem,
    input  logic        mem_write_mem,
    input  logic [2:0]  instr_funct3_mem,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] rs2_data_mem,
    input  logic        stall_ext,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] load_data_mem,
    output logic        stall_req,
    output logic        mem_fault,
    output logic        mem_fault_store
);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_RESP,
        ST_DONE
    } state_t;

    // Last count value at which a still-pending access gets aborted.
    localparam logic [CNT_W-1:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? CNT_W'(WAIT_LIMIT - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic        op;
    logic        funct3_ok;
    logic        aligned;
    logic        legal;
    logic        req_fire;
    logic        timeout_hit;
    logic [3:0]  strb_raw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    // Decode legality of the access held in EX/MEM.
    always_comb begin
        op = mem_read_mem | mem_write_mem;
        case (instr_funct3_mem)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = mem_read_mem;
            default:                funct3_ok = 1'b0;
        endcase
        case (instr_funct3_mem[1:0])
            2'b01:   aligned = ~alu_result_mem[0];
            2'b10:   aligned = (alu_result_mem[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        // Exactly one of read/write implies op is set.
        legal       = (mem_read_mem ^ mem_write_mem) & funct3_ok & aligned;
        req_fire    = dmem_req_valid & dmem_req_ready;
        timeout_hit = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT_M1);
    end

    // Request channel and hazard signalling follow the current state directly.
    always_comb begin
        dmem_req_valid = (state == ST_ISSUE) & legal;
        stall_req      = op & (state != ST_DONE);
        dmem_we        = mem_write_mem;
        dmem_addr      = {alu_result_mem[31:2], 2'b00};
    end

    // Store data replication and byte-lane enables.
    always_comb begin
        case (instr_funct3_mem[1:0])
            2'b00: begin
                dmem_wdata = {4{rs2_data_mem[7:0]}};
                strb_raw   = 4'b0001 << alu_result_mem[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{rs2_data_mem[15:0]}};
                strb_raw   = alu_result_mem[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dmem_wdata = rs2_data_mem;
                strb_raw   = 4'b1111;
            end
        endcase
        dmem_wstrb = mem_write_mem ? strb_raw : 4'b0000;
    end

    // Select the addressed byte/half of the read word and extend it.
    always_comb begin
        case (alu_result_mem[1:0])
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = alu_result_mem[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (instr_funct3_mem)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  load_ext = dmem_rdata;
            3'b100:  load_ext = {24'h000000, ld_byte};
            3'b101:  load_ext = {16'h0000, ld_half};
            default: load_ext = 32'h0000_0000;
        endcase
    end

    // Access sequencer: issue, wait for read data, then hold until the pipeline advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_ISSUE;
            wait_cnt        <= '0;
            load_data_mem   <= 32'h0000_0000;
            mem_fault       <= 1'b0;
            mem_fault_store <= 1'b0;
        end else begin
            mem_fault       <= 1'b0;
            mem_fault_store <= 1'b0;
            case (state)
                ST_ISSUE: begin
                    if (op && !legal) begin
                        state           <= ST_DONE;
                        wait_cnt        <= '0;
                        mem_fault       <= 1'b1;
                        mem_fault_store <= mem_write_mem;
                        load_data_mem   <= 32'h0000_0000;
                    end else if (dmem_req_valid) begin
                        if (req_fire) begin
                            state    <= mem_write_mem ? ST_DONE : ST_RESP;
                            wait_cnt <= '0;
                        end else if (timeout_hit) begin
                            state           <= ST_DONE;
                            wait_cnt        <= '0;
                            mem_fault       <= 1'b1;
                            mem_fault_store <= mem_write_mem;
                            load_data_mem   <= 32'h0000_0000;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                ST_RESP: begin
                    if (dmem_resp_valid) begin
                        state         <= ST_DONE;
                        wait_cnt      <= '0;
                        load_data_mem <= load_ext;
                    end else if (timeout_hit) begin
                        state           <= ST_DONE;
                        wait_cnt        <= '0;
                        mem_fault       <= 1'b1;
                        mem_fault_store <= mem_write_mem;
                        load_data_mem   <= 32'h0000_0000;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    wait_cnt <= '0;
                    if (!stall_ext) begin
                        state <= ST_ISSUE;
                    end
                end
                default: begin
                    state    <= ST_ISSUE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - self-checking bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_mem;
    logic        mem_write_mem;
    logic [2:0]  instr_funct3_mem;
    logic [31:0] alu_result_mem;
    logic [31:0] rs2_data_mem;
    logic        stall_ext;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_resp_valid;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data_mem;
    logic        stall_req;
    logic        mem_fault;
    logic        mem_fault_store;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_load = 32'h0;

    localparam int LIMIT = 4;

    mem_access_stage #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_mem     (mem_read_mem),
        .mem_write_mem    (mem_write_mem),
        .instr_funct3_mem (instr_funct3_mem),
        .alu_result_mem   (alu_result_mem),
        .rs2_data_mem     (rs2_data_mem),
        .stall_ext        (stall_ext),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_rdata       (dmem_rdata),
        .load_data_mem    (load_data_mem),
        .stall_req        (stall_req),
        .mem_fault        (mem_fault),
        .mem_fault_store  (mem_fault_store)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Runs one EX/MEM instruction to completion; called and returns at posedge+1.
    task automatic run_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] rdat,
                          input int rdy_d, input int rsp_d, input int hold);
        bit          op_b, lgl, is_fault, done, acc;
        int          size, a4, stalls_exp, hs_exp, stalls, hs, acc_c, bad, early;
        longint      v, mask;
        logic [31:0] wd_exp, ld_new, b32;
        logic [3:0]  st_exp;

        op_b = rd | wr;
        a4   = int'(addr[1:0]);
        size = 1 << f3[1:0];
        lgl  = (rd != wr) && (rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2))
               && ((int'(addr[2:0]) % size) == 0);
        if (size == 1)      begin b32 = {24'h0, wdat[7:0]};  wd_exp = b32 * 32'h0101_0101; end
        else if (size == 2) begin b32 = {16'h0, wdat[15:0]}; wd_exp = b32 * 32'h0001_0001; end
        else                wd_exp = wdat;
        st_exp = wr ? 4'(((1 << size) - 1) << a4) : 4'h0;
        v    = longint'({32'h0, rdat}) >> (8 * a4);
        mask = (longint'(1) << (8 * size)) - 1;
        v    = v & mask;
        if (!f3[2] && size < 4 && (((v >> (8 * size - 1)) & 1) == 1)) v = v | ~mask;
        if (!op_b)                 begin stalls_exp = 0;                 hs_exp = 0; is_fault = 0; end
        else if (!lgl)             begin stalls_exp = 1;                 hs_exp = 0; is_fault = 1; end
        else if (rdy_d >= LIMIT)   begin stalls_exp = LIMIT;             hs_exp = 0; is_fault = 1; end
        else if (wr)               begin stalls_exp = rdy_d + 1;         hs_exp = 1; is_fault = 0; end
        else if (rsp_d >= LIMIT)   begin stalls_exp = rdy_d + 1 + LIMIT; hs_exp = 1; is_fault = 1; end
        else                       begin stalls_exp = rdy_d + 2 + rsp_d; hs_exp = 1; is_fault = 0; end
        ld_new = is_fault ? 32'h0 : ((op_b && rd && lgl) ? v[31:0] : exp_load);

        mem_read_mem     = rd;
        mem_write_mem    = wr;
        instr_funct3_mem = f3;
        alu_result_mem   = addr;
        rs2_data_mem     = wdat;
        dmem_rdata       = rdat;
        stall_ext        = (hold > 0);
        dmem_req_ready   = (rdy_d == 0);
        dmem_resp_valid  = 1'b0;
        stalls = 0; hs = 0; acc = 0; acc_c = 0; done = 0; bad = 0; early = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                dmem_req_ready  = !acc && (c == rdy_d);
                dmem_resp_valid = acc && rd && (c - acc_c - 1 == rsp_d);
            end
            @(negedge clk);
            if (!stall_req) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_fault) early++;
                if (dmem_req_valid) begin
                    if (dmem_addr !== {addr[31:2], 2'b00} || dmem_we !== wr ||
                        (wr && (dmem_wdata !== wd_exp || dmem_wstrb !== st_exp)) ||
                        (!wr && dmem_wstrb !== 4'h0)) bad++;
                    if (dmem_req_ready) begin hs++; acc = 1; acc_c = c; end
                end
            end
        end
        exp_load = ld_new;
        check({nm, " reached_done"}, 32'(done), 32'd1);
        check({nm, " stall_cycles"}, stalls, stalls_exp);
        check({nm, " handshakes"}, hs, hs_exp);
        check({nm, " req_fields_bad"}, bad, 0);
        check({nm, " early_fault"}, early, 0);
        check({nm, " req_valid_in_done"}, 32'(dmem_req_valid), 32'd0);
        check({nm, " mem_fault"}, 32'(mem_fault), 32'(is_fault));
        check({nm, " mem_fault_store"}, 32'(mem_fault_store), 32'(is_fault & wr));
        check({nm, " load_data"}, load_data_mem, exp_load);
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            dmem_req_ready  = 1'b0;
            dmem_resp_valid = 1'b0;
            if (h == hold) stall_ext = 1'b0;
            @(negedge clk);
            check({nm, " held_done_quiet"}, {29'h0, stall_req, dmem_req_valid, mem_fault}, 32'h0);
            check({nm, " held_load"}, load_data_mem, exp_load);
        end
        @(posedge clk); #1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
    endtask

    initial begin
        logic       rd, wr;
        int         sel;
        logic [31:0] ra;

        rst = 1'b1;
        mem_read_mem = 0; mem_write_mem = 0; instr_funct3_mem = 3'b000;
        alu_result_mem = 32'h0; rs2_data_mem = 32'h0; stall_ext = 0;
        dmem_req_ready = 0; dmem_resp_valid = 0; dmem_rdata = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset outputs", {load_data_mem[29:0], mem_fault, mem_fault_store}, 32'h0);
        check("reset stall_valid", {30'h0, stall_req, dmem_req_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("lw_basic",  1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0);
        run_op("lb_sign",   1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, 0, 0);
        check("lb_value", load_data_mem, 32'hFFFFFF80);
        run_op("lbu",       1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, 1, 0);
        check("lbu_value", load_data_mem, 32'h00000080);
        run_op("lhu",       1, 0, 3'b101, 32'h102, 32'h0, 32'h80123456, 0, 0, 0);
        check("lhu_value", load_data_mem, 32'h00008012);
        run_op("sb",        0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0, 0, 0);
        run_op("sh",        0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, 0, 0);
        run_op("lw_misal",  1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 0);
        run_op("sw_wait3",  0, 1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 3, 0, 0);
        run_op("lw_tmo",    1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 10, 0, 0);
        run_op("lw_hold",   1, 0, 3'b010, 32'h104, 32'h0, 32'h11223344, 1, 1, 3);
        run_op("sbu_ill",   0, 1, 3'b100, 32'h104, 32'h55, 32'h0, 0, 0, 0);
        run_op("rd_wr",     1, 1, 3'b010, 32'h104, 32'h55, 32'h0, 0, 0, 0);

        // Reset while a load waits for its response.
        mem_read_mem = 1; mem_write_mem = 0; instr_funct3_mem = 3'b010;
        alu_result_mem = 32'h100; dmem_req_ready = 1;
        @(negedge clk);
        check("rst_resp req_valid", 32'(dmem_req_valid), 32'd1);
        @(posedge clk); #1;
        dmem_req_ready = 0; rst = 1;
        @(negedge clk);
        check("rst_resp in_resp_stall", 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        rst = 0; mem_read_mem = 0; dmem_resp_valid = 1; dmem_rdata = 32'h12345678;
        exp_load = 32'h0;
        @(negedge clk);
        check("rst_resp outputs", {load_data_mem[28:0], stall_req, dmem_req_valid, mem_fault}, 32'h0);
        @(posedge clk); #1;
        dmem_resp_valid = 0;
        @(negedge clk);
        check("rst_resp late_resp_ignored", load_data_mem, 32'h0);
        check("rst_resp no_fault", 32'(mem_fault), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      begin rd = 0; wr = 0; end
            else if (sel == 1) begin rd = 1; wr = 1; end
            else if (sel < 6)  begin rd = 1; wr = 0; end
            else               begin rd = 0; wr = 1; end
            ra = 32'h1000 + ($urandom & 32'hFF);
            run_op($sformatf("rand%0d", i), rd, wr, 3'($urandom_range(0, 7)), ra, $urandom, $urandom,
                   ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3),
                   $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
